// File: rtl/float_minmax_reduce.sv
// Streaming min/max/count reducer over framed IEEE-754 single-precision values.
// NaNs are excluded from ordering; ties keep the earlier element bit-exactly.
module float_minmax_reduce #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic [31:0]      din,
  input  logic             din_valid,
  input  logic             last,
  output logic             busy,
  output logic             done,
  output logic [31:0]      min_out,
  output logic [31:0]      max_out,
  output logic [CNT_W-1:0] count,
  output logic             nan_seen,
  output logic             empty
);

  localparam int          DATA_W = 32;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  function automatic logic is_nan(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (|x[22:0]);
  endfunction

  function automatic logic is_zero(input logic [DATA_W-1:0] x);
    return ~|x[30:0];
  endfunction

  // Unordered and +-0 pairs compare false; otherwise sign-magnitude order.
  function automatic logic lt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (is_nan(a) || is_nan(b))        return 1'b0;
    else if (is_zero(a) && is_zero(b)) return 1'b0;
    else if (a[31] != b[31])           return a[31];
    else if (a[31])                    return a[30:0] > b[30:0];
    else                               return a[30:0] < b[30:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Compare stage: single-cycle combinational against the accumulators
  logic din_nan, take_min, take_max;
  assign din_nan  = is_nan(din);
  assign take_min = lt(din, min_out);
  assign take_max = lt(max_out, din);

  // Register stage: FSM and accumulators
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      min_out  <= QNAN;
      max_out  <= QNAN;
      count    <= '0;
      nan_seen <= 1'b0;
      empty    <= 1'b1;
    end else if (ce) begin
      done <= 1'b0;
      if (start) begin
        state    <= RUN;
        busy     <= 1'b1;
        min_out  <= QNAN;
        max_out  <= QNAN;
        count    <= '0;
        nan_seen <= 1'b0;
        empty    <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (din_valid) begin
              if (din_nan) begin
                nan_seen <= 1'b1;
              end else if (empty) begin
                min_out <= din;
                max_out <= din;
                count   <= CNT_W'(1);
                empty   <= 1'b0;
              end else begin
                if (take_min) min_out <= din;
                if (take_max) max_out <= din;
                count <= sat_inc(count);
              end
              if (last) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/float_minmax_reduce.md
# float_minmax_reduce

Streaming reducer that accepts single-precision IEEE-754 values one per cycle and returns the running minimum, maximum and ordered-element count of a framed sequence. It sits downstream of the float compare stage in the generated datapath and uses the same less-than predicate, evaluated natively in fabric with no IP core. It serves min/max reductions over arrays without a round-trip through the scheduler.

## Interface
- CNT_W, 16, width of element counter; counter saturates at 2^CNT_W-1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ce  in  1  clock enable; 0 freezes FSM, registers and outputs
- start  in  1  begin new frame; sampled only when ce=1
- din  in  32  IEEE-754 single operand
- din_valid  in  1  din is valid this cycle
- last  in  1  qualifies din_valid; marks final element of frame
- busy  out  1  FSM in RUN
- done  out  1  one-cycle pulse; results valid
- min_out  out  32  minimum of ordered elements
- max_out  out  32  maximum of ordered elements
- count  out  CNT_W  number of non-NaN elements accepted
- nan_seen  out  1  at least one NaN accepted in frame
- empty  out  1  frame contained no ordered element

## Operation
- Predicate LT(x,y): false if either operand is NaN (exp=0xFF, mant!=0); ±0 compare equal; otherwise ordinary IEEE ordering (sign-magnitude compare, sign bit inverts the order).
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN. din_valid ignored.
  - RUN: accept when din_valid=1. last with din_valid -> DONE. start -> restart frame (RUN, accumulators cleared, din in that cycle ignored).
  - DONE: lasts one cycle, done=1 -> IDLE. start in DONE -> RUN directly.
- On entry to RUN: min/max accumulators = 0x7FC00000, count=0, nan_seen=0, empty=1.
- Accepted element, NaN: nan_seen=1. Nothing else changes.
- Accepted element, ordered, empty=1: min=max=din, count=1, empty=0.
- Accepted element, ordered, empty=0: min<=din if LT(din,min); max<=din if LT(max,din); count+1, saturating.
- Ties, including -0 vs +0: the accumulator keeps the earlier element bit-exactly.
- Outputs min_out/max_out/count/nan_seen/empty are the accumulator registers. They are valid when done=1 and hold until the next frame starts.
- If all elements are NaN or the frame is empty: min_out=max_out=0x7FC00000, count=0, empty=1.
- last without din_valid is ignored.

## Timing
- Reset values: busy=0, done=0, min_out=max_out=0x7FC00000, count=0, nan_seen=0, empty=1, FSM=IDLE.
- start at edge N (ce=1) -> busy=1 after edge N. The first element can be accepted at edge N+1.
- Throughput: one element per ce-qualified cycle, no backpressure.
- Latency: element accepted at edge N is reflected in outputs after edge N. With last at edge N, done=1 and busy=0 during cycle N+1.
- The ce=0 cycles insert no state change. A done pulse stays high until the next ce=1 edge.
- Reset asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock edge. The frame is discarded.
- The compare and select path is single-cycle combinational and must close timing at the datapath clock.

## Test plan
- Frame {0x3F800000 (1.0), 0xC0200000 (-2.5), 0x40400000 (3.0), 0x3F000000 (0.5, last)} -> done at cycle after last; min_out=0xC0200000, max_out=0x40400000, count=4, nan_seen=0, empty=0.
- Frame {0x80000000 (-0), 0x00000000 (+0, last)} -> min_out=max_out=0x80000000, count=2. Reversed order -> both 0x00000000.
- Frame {0x7FC00001, 0xFF800000 (-inf), 0x7F800000 (+inf, last)} -> min_out=0xFF800000, max_out=0x7F800000, count=2, nan_seen=1.
- Frame {0x7FC00001 (last)} only -> min_out=max_out=0x7FC00000, count=0, empty=1, nan_seen=1.
- ce toggled 0/1 every cycle during the first frame -> identical results, done pulse aligned to the ce=1 edge. start asserted mid-frame -> accumulators cleared and the new frame's results are independent.
- Reset asserted two cycles into a frame -> outputs at reset values before the next edge. busy=0, and no done pulse follows.
